// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the sequential carry-lookahead adder.
// Contents:
//   cla_seq_state_t : sequencer state encoding (idle / running / result held)
//   CHUNK_W         : width of the carry-lookahead leaf, bits processed per cycle
package cla_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } cla_seq_state_t;

    localparam int unsigned CHUNK_W = 4;

endpackage : cla_seq_pkg

// File: rtl/CLA4bit.sv
// 4-bit carry-lookahead adder leaf; purely combinational.
// Ports:
//   a, b : 4-bit addends
//   cin  : carry in
//   sum  : 4-bit sum
//   cout : carry out of bit 3
module CLA4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // All carries expanded directly from generate/propagate and cin
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum = p ^ c;

endmodule : CLA4bit

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor built around one shared 4-bit CLA leaf.
// One chunk is computed per cycle, LSB chunk first, with the carry held in a register.
// Optional feature: define CLA_SEQ_EARLY_EXIT_EN to finish an add early once the
// remaining operand bits are zero and no carry is pending (results are unchanged).
// Ports:
//   i_clk, i_rst_n       : clock, synchronous active-low reset
//   i_valid / o_ready    : request handshake
//   i_a, i_b, i_sub      : operands, 1 = A-B, 0 = A+B
//   o_valid / i_ready    : result handshake
//   o_sum, o_cout, o_ovf : result, carry out (subtract: 1 = no borrow), signed overflow
module cla_seq_adder
    import cla_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK_W;
    localparam int unsigned CNT_W  = $clog2(NCHUNK);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    cla_seq_state_t   state;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             a_msb;
    logic             b_msb;

    logic [CHUNK_W-1:0] leaf_sum;
    logic               leaf_cout;
    logic               last_chunk_c;
    logic               early_exit_c;

    CLA4bit u_leaf (
        .a    (a_sh[CHUNK_W-1:0]),
        .b    (b_sh[CHUNK_W-1:0]),
        .cin  (carry),
        .sum  (leaf_sum),
        .cout (leaf_cout)
    );

    assign last_chunk_c = (cnt == LAST_CNT);

`ifdef CLA_SEQ_EARLY_EXIT_EN
    logic sub_q;

    // Nothing left to add above this chunk and no carry to ripple into it
    assign early_exit_c = !last_chunk_c && !sub_q && !leaf_cout
                       && (a_sh[WIDTH-1:CHUNK_W] == '0) && (b_sh[WIDTH-1:CHUNK_W] == '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sub_q <= 1'b0;
        end else if (state == S_IDLE && i_valid && o_ready) begin
            sub_q <= i_sub;
        end
    end
`else
    assign early_exit_c = 1'b0;
`endif

    // Sequencer: accept, one chunk per RUN cycle, hold result until taken
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            o_ready <= 1'b0;
            o_valid <= 1'b0;
            o_sum   <= '0;
            o_cout  <= 1'b0;
            o_ovf   <= 1'b0;
            cnt     <= '0;
            carry   <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    o_ready <= 1'b1;
                    if (i_valid && o_ready) begin
                        a_sh    <= i_a;
                        b_sh    <= i_sub ? ~i_b : i_b;
                        a_msb   <= i_a[WIDTH-1];
                        b_msb   <= i_sub ? ~i_b[WIDTH-1] : i_b[WIDTH-1];
                        carry   <= i_sub;
                        cnt     <= '0;
                        o_ready <= 1'b0;
                        state   <= S_RUN;
                    end
                end

                S_RUN: begin
                    // Early exit clears the stale upper chunks; current chunk written below
                    if (early_exit_c) begin
                        for (int unsigned i = 0; i < NCHUNK; i++) begin
                            if (i > 32'(cnt)) begin
                                o_sum[i*CHUNK_W +: CHUNK_W] <= '0;
                            end
                        end
                        o_cout  <= 1'b0;
                        o_ovf   <= 1'b0;
                        o_valid <= 1'b1;
                        state   <= S_DONE;
                    end
                    o_sum[32'(cnt)*CHUNK_W +: CHUNK_W] <= leaf_sum;
                    carry <= leaf_cout;
                    a_sh  <= a_sh >> CHUNK_W;
                    b_sh  <= b_sh >> CHUNK_W;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_chunk_c) begin
                        o_cout  <= leaf_cout;
                        // Carry into MSB is a^b'^sum there; overflow when it differs from cout
                        o_ovf   <= a_msb ^ b_msb ^ leaf_sum[CHUNK_W-1] ^ leaf_cout;
                        o_valid <= 1'b1;
                        state   <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= S_IDLE;
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    o_valid <= 1'b0;
                    o_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule : cla_seq_adder

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder: directed vector table, handshake and
// reset sequences, then random operations against an arithmetic reference model.
module tb_cla_seq_adder;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NCHUNK = WIDTH / 4;
`ifdef CLA_SEQ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic             i_clk;
    logic             i_rst_n;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_sub;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_cout;
    logic             o_ovf;

    int errors = 0;
    int checks = 0;

    cla_seq_adder #(.WIDTH(WIDTH)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_sub   (i_sub),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_sum   (o_sum),
        .o_cout  (o_cout),
        .o_ovf   (o_ovf)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } vec_t;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: two's-complement arithmetic on a WIDTH+1 bit result
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                         output logic [WIDTH-1:0] sum, output logic cout, output logic ovf);
        logic [WIDTH-1:0] bv;
        logic [WIDTH:0]   full;
        bv   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bv} + (WIDTH+1)'(sub);
        sum  = full[WIDTH-1:0];
        cout = full[WIDTH];
        ovf  = (a[WIDTH-1] == bv[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    endtask

    // Edges from accept to o_valid: NCHUNK, or fewer when early exit applies
    function automatic int exp_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic sub);
        int  e;
        bit  found;
        logic [63:0] mask;
        logic [63:0] lo;
        e     = NCHUNK;
        found = 1'b0;
        if (!sub) begin
            for (int k = 0; k < int'(NCHUNK) - 1; k++) begin
                mask = (64'd1 << (4*k + 4)) - 64'd1;
                lo   = ({32'd0, a} & mask) + ({32'd0, b} & mask);
                if (!found && (lo >> (4*k + 4)) == 64'd0
                    && ({32'd0, a} >> (4*k + 4)) == 64'd0
                    && ({32'd0, b} >> (4*k + 4)) == 64'd0) begin
                    e     = k + 1;
                    found = 1'b1;
                end
            end
        end
        return EARLY ? e : int'(NCHUNK);
    endfunction

    // One full transaction; hold > 0 keeps i_ready low in DONE and pokes i_valid
    task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sub, input logic [WIDTH-1:0] esum, input logic ecout,
                          input logic eovf, input bit ready_early, input int hold);
        int n;
        n = 0;
        while (!o_ready && n < 20) begin
            tick();
            n++;
        end
        if (!o_ready) chk({name, "_ready_timeout"}, 64'(o_ready), 64'd1);
        i_a     = a;
        i_b     = b;
        i_sub   = sub;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        i_a     = $urandom;
        i_b     = $urandom;
        i_sub   = 1'($urandom_range(0, 1));
        i_ready = ready_early;
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_valid && n < 40);
        chk({name, "_lat"}, 64'(n), 64'(exp_lat(a, b, sub)));
        chk({name, "_sum"}, 64'(o_sum), 64'(esum));
        chk({name, "_cout"}, 64'(o_cout), 64'(ecout));
        chk({name, "_ovf"}, 64'(o_ovf), 64'(eovf));
        for (int i = 0; i < hold; i++) begin
            i_valid = 1'b1;
            i_a     = $urandom;
            tick();
            chk({name, "_hold_valid"}, 64'(o_valid), 64'd1);
            chk({name, "_hold_sum"}, 64'(o_sum), 64'(esum));
            chk({name, "_hold_ready"}, 64'(o_ready), 64'd0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk({name, "_valid_drop"}, 64'(o_valid), 64'd0);
        chk({name, "_idle_ready"}, 64'(o_ready), 64'd1);
    endtask

    initial begin
        vec_t             vecs[8];
        logic [WIDTH-1:0] a, b, s;
        logic             sub, c, v;

        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[4] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0007, 1'b0, 1'b0};
        vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_a     = '0;
        i_b     = '0;
        i_sub   = 1'b0;
        repeat (3) tick();
        chk("rst_ready", 64'(o_ready), 64'd0);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_sum", 64'(o_sum), 64'd0);
        chk("rst_cout", 64'(o_cout), 64'd0);
        chk("rst_ovf", 64'(o_ovf), 64'd0);
        i_rst_n = 1'b1;
        tick();
        chk("rel_ready", 64'(o_ready), 64'd1);

        // Directed vectors, last one with i_ready already high entering DONE
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
                   vecs[i].sum, vecs[i].cout, vecs[i].ovf, (i == 7), 0);
        end

        // Backpressure: 5 stalled cycles with an ignored request, then a fresh op
        run_op("bp", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 5);
        run_op("bp_next", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 0);

        // Reset while RUN is at chunk 3
        while (!o_ready) tick();
        i_a     = 32'hFFFF_FFFF;
        i_b     = 32'hFFFF_FFFF;
        i_sub   = 1'b0;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        repeat (3) tick();
        i_rst_n = 1'b0;
        tick();
        chk("abort_valid", 64'(o_valid), 64'd0);
        chk("abort_ready", 64'(o_ready), 64'd0);
        chk("abort_sum", 64'(o_sum), 64'd0);
        chk("abort_cout", 64'(o_cout), 64'd0);
        chk("abort_ovf", 64'(o_ovf), 64'd0);
        i_rst_n = 1'b1;
        tick();
        chk("abort_rel_ready", 64'(o_ready), 64'd1);
        chk("abort_rel_valid", 64'(o_valid), 64'd0);
        run_op("post_abort", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 0);

        // Random operations, a quarter with small operands to reach early exit
        for (int i = 0; i < 150; i++) begin
            a   = $urandom;
            b   = $urandom;
            sub = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                a = WIDTH'($urandom_range(0, 4095));
                b = WIDTH'($urandom_range(0, 255));
            end
            model(a, b, sub, s, c, v);
            run_op($sformatf("rnd%0d", i), a, b, sub, s, c, v, ($urandom_range(0, 1) == 1), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cla_seq_adder

// File: doc/cla_seq_adder.md
Name: cla_seq_adder

Overview:
- Multi-cycle WIDTH-bit adder/subtractor that time-shares a single 4-bit carry-lookahead leaf.
- Processes one 4-bit chunk per cycle, LSB chunk first, and ripples the carry through a register between cycles.
- Valid/ready handshake on both the input and the result side.
- Used where area matters more than latency, e.g. in the multi-cycle ALU path and for address offset computation.

Parameters:
- WIDTH, 32, operand/result width. Must be a multiple of 4 and at least 8.
- NCHUNK, WIDTH/4, number of chunks. Derived localparam; not overridable.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_valid  in  1  request valid.
- o_ready  out  1  block can accept a request.
- i_a  in  WIDTH  operand A.
- i_b  in  WIDTH  operand B.
- i_sub  in  1  1 = A-B, 0 = A+B.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts the result.
- o_sum  out  WIDTH  result.
- o_cout  out  1  carry out of the MSB. For subtract, 1 = no borrow.
- o_ovf  out  1  signed overflow.

Behaviour:
- Reset (i_rst_n=0 at a clock edge): state=IDLE, o_ready=0 during reset and 1 from the first cycle after release, o_valid=0, o_sum=0, o_cout=0, o_ovf=0, chunk counter=0, carry reg=0. Reset aborts any in-flight operation; no result is produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE: o_ready=1.
  - On i_valid&&o_ready: latch a_sh=i_a, b_sh=(i_sub ? ~i_b : i_b), carry=i_sub, sub_q=i_sub, cnt=0, then go to RUN.
  - With no i_valid, stay in IDLE.
- RUN: o_ready=0, o_valid=0. Each cycle:
  - Leaf inputs are a_sh[3:0], b_sh[3:0], carry.
  - Leaf sum is written to o_sum[4*cnt+:4]; carry<=leaf cout; a_sh/b_sh shift right by 4; cnt++.
  - When cnt==NCHUNK-1 in this cycle: o_cout<=leaf cout; o_ovf<=a_msb^b'_msb^sum_msb^leaf cout, using the latched MSBs of A and B'. Then go to DONE.
- DONE: o_valid=1, outputs held stable.
  - On i_ready, go to IDLE next cycle, o_valid drops.
  - i_valid is ignored outside IDLE; no skid buffer.
- Latency: accept edge + NCHUNK RUN cycles. o_valid is seen in cycle NCHUNK+1 after the accept edge (9 for WIDTH=32).
- Throughput: one operation per NCHUNK+2 cycles at best (accept, RUN, DONE/handshake).
- o_sum bits of chunks not yet computed hold stale data until DONE. The consumer may read o_sum only while o_valid=1.
- i_a/i_b/i_sub may change freely after the accept edge.
- If i_ready=1 already when entering DONE, o_valid is high for exactly one cycle.

Optional Feature:
- Macro: CLA_SEQ_EARLY_EXIT_EN.
- When defined, an early-exit check runs in RUN for chunks cnt<NCHUNK-1. Exit is taken only if all of the following hold:
  - sub_q=0;
  - leaf cout=0;
  - remaining a_sh[WIDTH-1:4]==0 and b_sh[WIDTH-1:4]==0.
- On exit:
  - o_sum bits above the current chunk <=0;
  - o_cout<=0, o_ovf<=0;
  - go directly to DONE.
- Without the macro, latency is always NCHUNK RUN cycles.
- Results are bit-identical with and without the macro.

Decomposition:
- Shared package cla_seq_pkg holds:
  - typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} cla_seq_state_t;
  - localparam CHUNK_W = 4.
- Counter width is $clog2(NCHUNK), computed locally.
- One sub-module: the existing 4-bit carry-lookahead leaf CLA4bit, instantiated once. It holds no state and all sequencing stays in cla_seq_adder.

Test Plan:
- Carry through every chunk: add 0xFFFFFFFF+0x00000001 -> o_sum=0x00000000, o_cout=1, o_ovf=0, o_valid 9 cycles after accept.
- Signed overflow on add: 0x7FFFFFFF+0x00000001 -> o_sum=0x80000000, o_cout=0, o_ovf=1.
- Subtract: sub 5-7 -> o_sum=0xFFFFFFFE, o_cout=0 (borrow), o_ovf=0. Sub 0x80000000-1 -> 0x7FFFFFFF, o_cout=1, o_ovf=1.
- Backpressure: hold i_ready=0 for 5 cycles in DONE -> o_valid/o_sum stable, o_ready=0, a second i_valid is ignored. Release -> IDLE next cycle, then the next op is accepted.
- Reset mid-operation: i_rst_n=0 at RUN cnt=3 -> next cycle all outputs 0. After release, a new op 0x12345678+0x11111111 -> 0x23456789 with no residue from the aborted op.
- Early exit (with CLA_SEQ_EARLY_EXIT_EN): 3+4 -> o_sum=0x00000007 after 1 RUN cycle. Same stimulus without the macro -> identical result after 8 RUN cycles.
